seg7_scan_mux: RTL and testbench

Downstream display stage for the MM:SS clock block. Consumes its four 7-bit active-low segment patterns (hex0..hex3) and time-multiplexes them onto one shared segment bus with four active-low digit enables, as a common-anode 4-digit module needs. Adds per-digit blanking, a colon/decimal-point input, 16-level brightness PWM, a lamp test, and frame-synchronous input latching so digits never tear mid-frame.

---
 rtl/seg7_scan_mux.sv | 99 +++++++++
 tb/tb_seg7_scan_mux.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode scan multiplexer for the MM:SS display.
// Each digit owns one slot of DIV clocks, split into 16 PWM phases; phase 0 is
// a dark guard interval. Digit patterns, DPs and blanks are latched once per
// frame so a digit never changes partway through a frame.
module seg7_scan_mux #(
    parameter int DIV = 12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank,
    input  logic [3:0] bright,
    input  logic       lamp_test,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [3:0] dig_out,
    output logic       frame_tick
);

    localparam int SUB = DIV / 16;
    localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SUB - 1);

    logic [SW-1:0]       sub_q, sub_d;
    logic [3:0]          phase_q, phase_d;
    logic [1:0]          dig_q, dig_d;
    logic [3:0][6:0]     hex_sh_q;
    logic [3:0]          dp_sh_q, blank_sh_q;
    logic [6:0]          seg_d;
    logic                dp_d, tick_d, lit, frame;
    logic [3:0]          dig_out_d;

    // Counter chain: sub-phase ticks -> PWM phase -> digit index.
    always_comb begin
        sub_d   = sub_q + 1'b1;
        phase_d = phase_q;
        dig_d   = dig_q;
        if (sub_q == SUB_LAST) begin
            sub_d   = '0;
            phase_d = phase_q + 4'd1;
            if (phase_q == 4'd15) dig_d = dig_q + 2'd1;
        end
    end

    // Lit decision and next output values for the current counter state.
    always_comb begin
        frame     = (dig_q == 2'd0) && (phase_q == 4'd0) && (sub_q == '0);
        lit       = (phase_q != 4'd0) &&
                    (lamp_test || (!blank_sh_q[dig_q] && (phase_q <= bright)));
        tick_d    = frame;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        dig_out_d = 4'hF;
        if (lit) begin
            dig_out_d = ~(4'b0001 << dig_q);
            seg_d     = lamp_test ? 7'h00 : hex_sh_q[dig_q];
            dp_d      = lamp_test ? 1'b0 : ~dp_sh_q[dig_q];
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q      <= '0;
            phase_q    <= '0;
            dig_q      <= '0;
            seg_out    <= 7'h7F;
            dp_out     <= 1'b1;
            dig_out    <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            sub_q      <= sub_d;
            phase_q    <= phase_d;
            dig_q      <= dig_d;
            seg_out    <= seg_d;
            dp_out     <= dp_d;
            dig_out    <= dig_out_d;
            frame_tick <= tick_d;
        end
    end

    // Frame-synchronous shadow copy of the per-digit inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_sh_q   <= {4{7'h7F}};
            dp_sh_q    <= 4'h0;
            blank_sh_q <= 4'hF;
        end else if (frame) begin
            hex_sh_q   <= {hex3, hex2, hex1, hex0};
            dp_sh_q    <= dp_in;
            blank_sh_q <= blank;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  localparam int DIV   = 32;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [3:0] dp_in, blank, bright;
  logic       lamp_test;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] dig_out;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  logic [12:0] expq[$];

  seg7_scan_mux #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .dp_in(dp_in), .blank(blank), .bright(bright), .lamp_test(lamp_test),
    .seg_out(seg_out), .dp_out(dp_out), .dig_out(dig_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    int         t;
    logic [6:0] sh_hex[4];
    logic [3:0] sh_dp, sh_blank;
    t = 0;
    sh_dp = 4'h0;
    sh_blank = 4'hF;
    for (int i = 0; i < 4; i++) sh_hex[i] = 7'h7F;
    forever begin
      @(posedge clk);
      if (reset) begin
        t = 0;
        sh_dp = 4'h0;
        sh_blank = 4'hF;
        for (int i = 0; i < 4; i++) sh_hex[i] = 7'h7F;
        expq.push_back({1'b0, 4'hF, 7'h7F, 1'b1});
      end else begin
        int pos, d, ph;
        logic lit;
        logic [3:0] edig;
        logic [6:0] eseg;
        logic edp;
        pos = t % FRAME;
        d   = pos / DIV;
        ph  = (pos % DIV) / (DIV / 16);
        if (pos == 0) begin
          sh_hex[0] = hex0; sh_hex[1] = hex1;
          sh_hex[2] = hex2; sh_hex[3] = hex3;
          sh_dp = dp_in;
          sh_blank = blank;
        end
        lit = (ph != 0) && (lamp_test || (!sh_blank[d] && ph <= int'(bright)));
        edig = 4'hF; eseg = 7'h7F; edp = 1'b1;
        if (lit) begin
          edig = 4'hF;
          edig[d] = 1'b0;
          eseg = lamp_test ? 7'h00 : sh_hex[d];
          edp  = lamp_test ? 1'b0 : ~sh_dp[d];
        end
        expq.push_back({pos == 0, edig, eseg, edp});
        t++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        logic [12:0] e, a;
        e = expq.pop_front();
        a = {frame_tick, dig_out, seg_out, dp_out};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got tick=%b dig=%h seg=%h dp=%b, want tick=%b dig=%h seg=%h dp=%b",
                   $time, a[12], a[11:8], a[7:1], a[0], e[12], e[11:8], e[7:1], e[0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset();
    checks++;
    if (seg_out !== 7'h7F || dp_out !== 1'b1 || dig_out !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset state t=%0t: seg=%h dp=%b dig=%h tick=%b",
               $time, seg_out, dp_out, dig_out, frame_tick);
    end
  endtask

  task automatic wait_tick(input int limit);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL wait for frame_tick expired after %0d cycles t=%0t", limit, $time);
    end
  endtask

  task automatic rand_inputs();
    hex0 = 7'($urandom); hex1 = 7'($urandom);
    hex2 = 7'($urandom); hex3 = 7'($urandom);
    dp_in = 4'($urandom); blank = 4'($urandom);
    bright = 4'($urandom); lamp_test = 1'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    rand_inputs();
    cyc(1); check_reset(); rand_inputs();
    cyc(1); check_reset(); rand_inputs();
    cyc(1); check_reset();
    reset = 1'b0;
    hex0 = 7'h40; hex1 = 7'h79; hex2 = 7'h24; hex3 = 7'h30;
    dp_in = 4'h0; blank = 4'h0; bright = 4'd15; lamp_test = 1'b0;
    cyc(2 * FRAME);
    bright = 4'd4;  cyc(FRAME);
    bright = 4'd0;  cyc(FRAME);
    bright = 4'd15;
    cyc(2 * DIV + 10);
    hex1 = 7'h12;
    cyc(2 * FRAME - 2 * DIV - 10);
    blank = 4'b0100; dp_in = 4'b0100;
    cyc(2 * FRAME);
    lamp_test = 1'b1; bright = 4'd0;
    cyc(FRAME);
    lamp_test = 1'b0; bright = 4'd15;
    cyc(3 * DIV + 7);
    reset = 1'b1; cyc(1); reset = 1'b0;
    wait_tick(FRAME + 2);
    cyc(2 * FRAME);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rand_inputs();
      reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(3);
    wait_tick(FRAME + 2);
    cyc(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
